// File: rtl/cpu_pkg.sv
// Shared types and encodings for the fetch/decode/control stage.
package cpu_pkg;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;

    typedef enum logic [4:0] {
        S_RESET, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE,
        S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG,
        S_ADDR, S_LOAD_DA, S_MEM_RD, S_WRITE_MEM,
        S_GET_RD, S_MOV_B, S_MEM_WR, S_HALT
    } state_e;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MEM     = 2'b00;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [3:0] VSEL_MDATA  = 4'b0001;
    localparam logic [3:0] VSEL_SXIMM8 = 4'b0010;
    localparam logic [3:0] VSEL_PC     = 4'b0100;
    localparam logic [3:0] VSEL_C      = 4'b1000;

    // Instruction classes; anything undefined decodes to IC_HALT.
    typedef enum logic [2:0] {
        IC_MOVI, IC_MOV, IC_ALU, IC_CMP, IC_LDR, IC_STR, IC_HALT
    } iclass_e;

    typedef struct packed {
        logic [1:0]    mem_cmd;
        logic [AW-1:0] mem_addr;
        logic [3:0]    vsel;
        logic [2:0]    writenum;
        logic [2:0]    readnum;
        logic          write;
        logic          loada;
        logic          loadb;
        logic          loadc;
        logic          loads;
        logic          asel;
        logic          bsel;
        logic [1:0]    shift;
        logic [1:0]    alu_op;
        logic          halted;
    } ctrl_t;

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decoder: IR fields, sign-extended immediates, class.
module instr_dec
    import cpu_pkg::*;
(
    input  logic [DW-1:0] ir,
    output logic [2:0]    rn_c,
    output logic [2:0]    rd_c,
    output logic [2:0]    rm_c,
    output logic [1:0]    op_c,
    output logic [1:0]    sh_c,
    output logic [DW-1:0] sximm8_c,
    output logic [DW-1:0] sximm5_c,
    output iclass_e       iclass_c
);

    logic [2:0] opcode;

    always_comb begin
        opcode   = ir[15:13];
        op_c     = ir[12:11];
        rn_c     = ir[10:8];
        rd_c     = ir[7:5];
        sh_c     = ir[4:3];
        rm_c     = ir[2:0];
        sximm8_c = {{8{ir[7]}}, ir[7:0]};
        sximm5_c = {{11{ir[4]}}, ir[4:0]};
        case ({opcode, op_c})
            {OPC_MOV, OP_MOV_IMM}:                      iclass_c = IC_MOVI;
            {OPC_MOV, OP_MOV_REG}, {OPC_ALU, OP_MVN}:   iclass_c = IC_MOV;
            {OPC_ALU, OP_ADD}, {OPC_ALU, OP_AND}:       iclass_c = IC_ALU;
            {OPC_ALU, OP_CMP}:                          iclass_c = IC_CMP;
            {OPC_LDR, OP_MEM}:                          iclass_c = IC_LDR;
            {OPC_STR, OP_MEM}:                          iclass_c = IC_STR;
            default:                                    iclass_c = IC_HALT;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Fetch/decode/control FSM owning PC, IR and DA; all outputs are registered
// Moore outputs computed from the next state so they line up with state_q.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] read_data,
    input  logic [DW-1:0] datapath_out,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] sximm8,
    output logic [DW-1:0] sximm5,
    output logic [3:0]    vsel,
    output logic [2:0]    writenum,
    output logic [2:0]    readnum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic [AW-1:0] pc,
    output logic          halted
);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, da_q, da_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] sximm8_q, sximm5_q;
    ctrl_t         ctrl_q, ctrl_d;

    logic [2:0]    rn, rd, rm;
    logic [1:0]    op, sh;
    logic [DW-1:0] sximm8_c, sximm5_c;
    iclass_e       iclass;
    logic          unused_dp_hi;

    assign unused_dp_hi = ^datapath_out[DW-1:AW];

    // Decoding ir_d is safe for next-state: ir_d differs from ir_q only in IF2.
    instr_dec u_dec (
        .ir       (ir_d),
        .rn_c     (rn),
        .rd_c     (rd),
        .rm_c     (rm),
        .op_c     (op),
        .sh_c     (sh),
        .sximm8_c (sximm8_c),
        .sximm5_c (sximm5_c),
        .iclass_c (iclass)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        da_d    = da_q;
        case (state_q)
            S_RESET:     state_d = S_IF1;
            S_IF1:       state_d = S_IF2;
            S_IF2: begin
                ir_d    = read_data;
                state_d = S_UPDATE_PC;
            end
            S_UPDATE_PC: begin
                pc_d    = pc_q + AW'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (iclass)
                    IC_MOVI: state_d = S_WRITE_IMM;
                    IC_MOV:  state_d = S_GET_B;
                    IC_HALT: state_d = S_HALT;
                    default: state_d = S_GET_A;
                endcase
            end
            S_GET_A:     state_d = (iclass == IC_LDR || iclass == IC_STR) ? S_ADDR : S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU:       state_d = (iclass == IC_CMP) ? S_IF1 : S_WRITE_REG;
            S_ADDR:      state_d = S_LOAD_DA;
            S_LOAD_DA: begin
                da_d    = datapath_out[AW-1:0];
                state_d = (iclass == IC_LDR) ? S_MEM_RD : S_GET_RD;
            end
            S_MEM_RD:    state_d = S_WRITE_MEM;
            S_GET_RD:    state_d = S_MOV_B;
            S_MOV_B:     state_d = S_MEM_WR;
            S_WRITE_IMM, S_WRITE_REG, S_WRITE_MEM, S_MEM_WR: state_d = S_IF1;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_HALT;
        endcase
    end

    // Output decode for the state being entered.
    always_comb begin
        ctrl_d          = '0;
        ctrl_d.mem_addr = pc_d;
        case (state_d)
            S_IF1, S_IF2: ctrl_d.mem_cmd = MEM_READ;
            S_WRITE_IMM: begin
                ctrl_d.writenum = rn;
                ctrl_d.vsel     = VSEL_SXIMM8;
                ctrl_d.write    = 1'b1;
            end
            S_GET_A: begin
                ctrl_d.readnum = rn;
                ctrl_d.loada   = 1'b1;
            end
            S_GET_B: begin
                ctrl_d.readnum = rm;
                ctrl_d.loadb   = 1'b1;
            end
            S_ALU: begin
                ctrl_d.shift  = sh;
                ctrl_d.alu_op = op;
                ctrl_d.loadc  = 1'b1;
                ctrl_d.asel   = (iclass == IC_MOV);
                ctrl_d.loads  = (iclass == IC_CMP);
            end
            S_WRITE_REG: begin
                ctrl_d.writenum = rd;
                ctrl_d.vsel     = VSEL_C;
                ctrl_d.write    = 1'b1;
            end
            S_ADDR: begin
                ctrl_d.bsel  = 1'b1;
                ctrl_d.loadc = 1'b1;
            end
            S_MEM_RD: begin
                ctrl_d.mem_addr = da_d;
                ctrl_d.mem_cmd  = MEM_READ;
            end
            S_WRITE_MEM: begin
                ctrl_d.mem_addr = da_d;
                ctrl_d.mem_cmd  = MEM_READ;
                ctrl_d.vsel     = VSEL_MDATA;
                ctrl_d.writenum = rd;
                ctrl_d.write    = 1'b1;
            end
            S_GET_RD: begin
                ctrl_d.readnum = rd;
                ctrl_d.loadb   = 1'b1;
            end
            S_MOV_B: begin
                ctrl_d.asel  = 1'b1;
                ctrl_d.loadc = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_d.mem_addr = da_d;
                ctrl_d.mem_cmd  = MEM_WRITE;
            end
            S_HALT:  ctrl_d.halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_RESET;
            pc_q     <= '0;
            ir_q     <= '0;
            da_q     <= '0;
            sximm8_q <= '0;
            sximm5_q <= '0;
            ctrl_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            da_q     <= da_d;
            sximm8_q <= sximm8_c;
            sximm5_q <= sximm5_c;
            ctrl_q   <= ctrl_d;
        end
    end

    assign mem_cmd  = ctrl_q.mem_cmd;
    assign mem_addr = ctrl_q.mem_addr;
    assign vsel     = ctrl_q.vsel;
    assign writenum = ctrl_q.writenum;
    assign readnum  = ctrl_q.readnum;
    assign write    = ctrl_q.write;
    assign loada    = ctrl_q.loada;
    assign loadb    = ctrl_q.loadb;
    assign loadc    = ctrl_q.loadc;
    assign loads    = ctrl_q.loads;
    assign asel     = ctrl_q.asel;
    assign bsel     = ctrl_q.bsel;
    assign shift    = ctrl_q.shift;
    assign ALUop    = ctrl_q.alu_op;
    assign halted   = ctrl_q.halted;
    assign sximm8   = sximm8_q;
    assign sximm5   = sximm5_q;
    assign pc       = pc_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench: a per-instruction cycle model of the controller's
// outputs driven by a small program memory and random datapath values.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] read_data;
    logic [15:0] datapath_out;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] sximm8, sximm5;
    logic [3:0]  vsel;
    logic [2:0]  writenum, readnum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic [8:0]  pc;
    logic        halted;

    cpu_controller dut (
        .clk(clk), .reset_n(reset_n), .read_data(read_data), .datapath_out(datapath_out),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .sximm8(sximm8), .sximm5(sximm5),
        .vsel(vsel), .writenum(writenum), .readnum(readnum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel),
        .bsel(bsel), .shift(shift), .ALUop(ALUop), .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] s8, s5;
        logic [3:0]  vsel;
        logic [2:0]  wnum, rnum;
        logic        wr, la, lb, lc, ls, as, bs;
        logic [1:0]  sh, alu;
        logic [8:0]  pc;
        logic        halt;
    } obs_t;

    logic [15:0] mem [512];
    int          n_total = 0;
    int          n_bad   = 0;
    logic [8:0]  m_pc;
    logic [15:0] m_ir;
    logic [8:0]  m_da;
    bit          dp_force_en = 1'b0;
    logic [15:0] dp_force    = 16'h0;

    // Synchronous memory: data valid one cycle after a READ address.
    always @(posedge clk) if (mem_cmd == 2'b01) read_data <= mem[mem_addr];

    task automatic check_eq(input string tag, input obs_t got, input obs_t exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o = '{cmd: mem_cmd, addr: mem_addr, s8: sximm8, s5: sximm5, vsel: vsel,
              wnum: writenum, rnum: readnum, wr: write, la: loada, lb: loadb,
              lc: loadc, ls: loads, as: asel, bs: bsel, sh: shift, alu: ALUop,
              pc: pc, halt: halted};
        return o;
    endfunction

    function automatic obs_t base();
        obs_t o = '0;
        o.addr = m_pc;
        o.pc   = m_pc;
        o.s8   = 16'($signed(m_ir[7:0]));
        o.s5   = 16'($signed(m_ir[4:0]));
        return o;
    endfunction

    task automatic tick(output logic [15:0] dp);
        dp = dp_force_en ? dp_force : 16'($urandom);
        datapath_out = dp;
        @(negedge clk);
    endtask

    task automatic cyc(input string tag, input obs_t e);
        logic [15:0] d;
        check_eq(tag, sample(), e);
        tick(d);
    endtask

    task automatic assert_reset();
        #2 reset_n = 1'b0;
        #1 check_eq("rst_async", sample(), '0);
        m_pc = '0; m_ir = '0; m_da = '0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        check_eq("rst_state", sample(), '0);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic exec_one(input bit rst_in_alu, input int halt_cycles);
        obs_t        e;
        logic [2:0]  opc, rn, rd, rm;
        logic [1:0]  op, sh;
        logic [15:0] d;
        e = base(); e.cmd = 2'b01;
        cyc("if1", e);
        cyc("if2", e);
        m_ir = mem[m_pc];
        cyc("update_pc", base());
        m_pc = m_pc + 9'd1;
        cyc("decode", base());
        opc = m_ir[15:13]; op = m_ir[12:11]; rn = m_ir[10:8];
        rd = m_ir[7:5]; sh = m_ir[4:3]; rm = m_ir[2:0];
        if (opc == 3'b110 && op == 2'b10) begin
            e = base(); e.wnum = rn; e.vsel = 4'b0010; e.wr = 1'b1;
            cyc("write_imm", e);
        end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
            e = base(); e.rnum = rm; e.lb = 1'b1; cyc("mov_get_b", e);
            e = base(); e.sh = sh; e.alu = op; e.lc = 1'b1; e.as = 1'b1; cyc("mov_alu", e);
            e = base(); e.wnum = rd; e.vsel = 4'b1000; e.wr = 1'b1; cyc("mov_write_reg", e);
        end else if (opc == 3'b101) begin
            e = base(); e.rnum = rn; e.la = 1'b1; cyc("get_a", e);
            e = base(); e.rnum = rm; e.lb = 1'b1; cyc("get_b", e);
            e = base(); e.sh = sh; e.alu = op; e.lc = 1'b1; e.ls = (op == 2'b01);
            if (rst_in_alu) begin
                check_eq("alu_before_rst", sample(), e);
                assert_reset();
                return;
            end
            cyc("alu", e);
            if (op != 2'b01) begin
                e = base(); e.wnum = rd; e.vsel = 4'b1000; e.wr = 1'b1; cyc("write_reg", e);
            end
        end else if ((opc == 3'b011 || opc == 3'b100) && op == 2'b00) begin
            e = base(); e.rnum = rn; e.la = 1'b1; cyc("mem_get_a", e);
            e = base(); e.bs = 1'b1; e.lc = 1'b1; cyc("addr", e);
            check_eq("load_da", sample(), base());
            tick(d);
            m_da = d[8:0];
            if (opc == 3'b011) begin
                e = base(); e.addr = m_da; e.cmd = 2'b01; cyc("mem_rd", e);
                e.vsel = 4'b0001; e.wnum = rd; e.wr = 1'b1; cyc("write_mem", e);
            end else begin
                e = base(); e.rnum = rd; e.lb = 1'b1; cyc("get_rd", e);
                e = base(); e.as = 1'b1; e.lc = 1'b1; cyc("mov_b", e);
                e = base(); e.addr = m_da; e.cmd = 2'b10; cyc("mem_wr", e);
            end
        end else begin
            e = base(); e.halt = 1'b1;
            repeat (halt_cycles) cyc("halt", e);
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r = 16'($urandom);
        case ($urandom_range(0, 7))
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2: r[15:11] = 5'b10111;
            3: r[15:11] = 5'b10100;
            4: r[15:11] = 5'b10110;
            5: r[15:11] = 5'b10101;
            6: r[15:11] = 5'b01100;
            default: r[15:11] = 5'b10000;
        endcase
        return r;
    endfunction

    initial begin
        logic [15:0] undef [3];
        undef[0] = 16'h0000; undef[1] = 16'h6800; undef[2] = 16'hD800;
        reset_n = 1'b0;
        datapath_out = 16'h0;
        m_pc = '0; m_ir = '0; m_da = '0;
        for (int i = 0; i < 512; i++) mem[i] = 16'hE000;
        repeat (2) @(negedge clk);
        check_eq("rst_init", sample(), '0);

        // Reset asserted in the middle of an ADD.
        mem[0] = 16'hA148;
        release_reset();
        exec_one(1'b1, 0);

        // Directed instructions, random mix, then STR and HALT.
        mem[0] = 16'hD0FB;
        mem[1] = 16'hA148;
        mem[2] = 16'hA900;
        mem[3] = 16'h617E;
        for (int i = 4; i < 34; i++) mem[i] = rand_instr();
        mem[34] = 16'h8261;
        mem[35] = 16'hE000;
        release_reset();
        for (int i = 0; i < 36; i++) begin
            dp_force_en = (i == 3);
            dp_force    = 16'h0105;
            exec_one(1'b0, 25);
        end
        dp_force_en = 1'b0;

        // Undefined encodings behave as HALT.
        for (int k = 0; k < 3; k++) begin
            assert_reset();
            mem[0] = undef[k];
            release_reset();
            exec_one(1'b0, 5);
        end

        // PC wrap: fetch all 512 addresses, then HALT back at address 0.
        assert_reset();
        for (int i = 0; i < 512; i++) mem[i] = {5'b11010, 11'($urandom)};
        release_reset();
        exec_one(1'b0, 0);
        mem[0] = 16'hE000;
        for (int i = 1; i < 512; i++) exec_one(1'b0, 0);
        exec_one(1'b0, 22);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
